// File: rtl/hazard_ctrl_pkg.sv
// Shared issue-pipeline definitions: latency defaults, controller state encoding
// and counter sizing helper.
package hazard_ctrl_pkg;

  localparam int unsigned LOAD_LAT_DEF  = 2;
  localparam int unsigned ALU_LAT_DEF   = 0;
  localparam int unsigned FLUSH_CYC_DEF = 1;

  // Flush window never exceeds 3 cycles.
  localparam int unsigned FCNT_W = 2;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

  // Counter width able to hold LOAD_LAT, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard for in-flight writes, with two
// combinational busy lookups for the source operands in ID.
module reg_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [4:0]       wr_rd_i,
  input  logic [CNT_W-1:0] wr_val_i,
  input  logic [4:0]       rd_a_i,
  input  logic [4:0]       rd_b_i,
  output logic             busy_a_o,
  output logic             busy_b_o
);

  // x0 has no entry; it is never busy.
  logic [CNT_W-1:0] cnt_q [1:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (wr_en_i && (wr_rd_i == 5'(i))) begin
          cnt_q[i] <= wr_val_i;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // A count of 1 means the result lands this cycle and is forwarded, so only
  // counts above 1 interlock; this gives LAT-1 stall cycles for a LAT writer.
  always_comb begin
    busy_a_o = 1'b0;
    busy_b_o = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((rd_a_i == 5'(i)) && (cnt_q[i] > CNT_W'(1))) busy_a_o = 1'b1;
      if ((rd_b_i == 5'(i)) && (cnt_q[i] > CNT_W'(1))) busy_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue-side controller: load-aware operand interlock plus a redirect FSM
// that opens a fixed flush window after jumps and taken branches.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LAT  = LOAD_LAT_DEF,
  parameter int unsigned ALU_LAT   = ALU_LAT_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        id_jmp,
  input  logic [31:0] id_jmp_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_pc,
  output logic        issue,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = cnt_width(LOAD_LAT);

  hz_state_e         state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              busy_rs1, busy_rs2;
  logic              hazard;
  logic              sb_wr_en;
  logic [CNT_W-1:0]  sb_wr_val;

  assign hazard = id_valid && ((id_use_rs1 && busy_rs1) || (id_use_rs2 && busy_rs2));

  assign sb_wr_en  = issue && id_regwrite && (id_rd != 5'd0);
  assign sb_wr_val = id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

  reg_scoreboard #(
    .CNT_W(CNT_W)
  ) u_sb (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_en_i (sb_wr_en),
    .wr_rd_i (id_rd),
    .wr_val_i(sb_wr_val),
    .rd_a_i  (id_rs1),
    .rd_b_i  (id_rs2),
    .busy_a_o(busy_rs1),
    .busy_b_o(busy_rs2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_br_taken || (!hazard && id_valid && id_jmp)) begin
          if (FLUSH_CYC != 0) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYC);
          end
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held so the pipeline sees no
  // spurious redirect or bubble during an asynchronous reset pulse.
  always_comb begin
    issue       = 1'b0;
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            redirect    = 1'b1;
            redirect_pc = ex_br_pc;
            flush_id    = 1'b1;
            bubble_ex   = 1'b1;
          end else if (hazard) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (id_valid && id_jmp) begin
            issue       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = id_jmp_pc;
            flush_id    = 1'b1;
          end else if (id_valid) begin
            issue = 1'b1;
          end else begin
            bubble_ex = 1'b1;
          end
        end
        FLUSH: begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with default latencies
// (LOAD_LAT=2, ALU_LAT=0, FLUSH_CYC=1).
module tb_hazard_ctrl;

  localparam logic [4:0] C_ISSUE = 5'b10000;
  localparam logic [4:0] C_STALL = 5'b01000;
  localparam logic [4:0] C_BUB   = 5'b00100;
  localparam logic [4:0] C_FL    = 5'b00010;
  localparam logic [4:0] C_RDR   = 5'b00001;
  localparam logic [4:0] C_NONE  = 5'b00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_regwrite, id_is_load, id_jmp;
  logic [31:0] id_jmp_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_pc;
  logic        issue, stall_if, bubble_ex, flush_id, redirect;
  logic [31:0] redirect_pc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .LOAD_LAT (2),
    .ALU_LAT  (0),
    .FLUSH_CYC(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_is_load (id_is_load),
    .id_jmp     (id_jmp),
    .id_jmp_pc  (id_jmp_pc),
    .ex_br_taken(ex_br_taken),
    .ex_br_pc   (ex_br_pc),
    .issue      (issue),
    .stall_if   (stall_if),
    .bubble_ex  (bubble_ex),
    .flush_id   (flush_id),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] exp_ctl, input logic [31:0] exp_pc);
    chk({tag, ".ctl"}, {27'b0, issue, stall_if, bubble_ex, flush_id, redirect}, {27'b0, exp_ctl});
    chk({tag, ".pc"}, redirect_pc, exp_pc);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic jmp, input logic [31:0] jpc,
                       input logic br, input logic [31:0] bpc);
    id_valid    = v;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_jmp      = jmp;
    id_jmp_pc   = jpc;
    ex_br_taken = br;
    ex_br_pc    = bpc;
  endtask

  // Apply one cycle of ID/EX inputs, check outputs mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic jmp, input logic [31:0] jpc,
                      input logic br, input logic [31:0] bpc,
                      input logic [4:0] exp_ctl, input logic [31:0] exp_pc);
    drive(v, rs1, u1, rs2, u2, rd, rw, ld, jmp, jpc, br, bpc);
    #3;
    check_out(tag, exp_ctl, exp_pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_out("reset", C_NONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    step("idle",     0, 0,0, 0,0,  0,0,0, 0,0, 0,0, C_BUB, 0);

    // load-use: one stall cycle, then issue
    step("ld_x5",    1, 0,0, 0,0,  5,1,1, 0,0, 0,0, C_ISSUE, 0);
    step("use_stl",  1, 5,1, 1,1,  6,1,0, 0,0, 0,0, C_STALL | C_BUB, 0);
    step("use_iss",  1, 5,1, 1,1,  6,1,0, 0,0, 0,0, C_ISSUE, 0);

    // ALU back-to-back forwards without interlock
    step("addi_x3",  1, 0,1, 0,0,  3,1,0, 0,0, 0,0, C_ISSUE, 0);
    step("add_x3",   1, 3,1, 6,1,  7,1,0, 0,0, 0,0, C_ISSUE, 0);

    // writes to x0 are never tracked
    step("ld_x0",    1, 0,0, 0,0,  0,1,1, 0,0, 0,0, C_ISSUE, 0);
    step("rd_x0",    1, 0,1, 0,1, 11,1,0, 0,0, 0,0, C_ISSUE, 0);

    // taken branch beats a hazard; branch in FLUSH is ignored
    step("ld_x8",    1, 0,0, 0,0,  8,1,1, 0,0, 0,0, C_ISSUE, 0);
    step("br_hz",    1, 8,1, 0,0, 12,1,0, 0,0, 1,32'h100, C_RDR | C_FL | C_BUB, 32'h100);
    step("br_fl",    1, 0,0, 0,0, 12,1,0, 0,0, 1,32'h200, C_FL | C_BUB, 0);
    step("br_run",   1, 8,1, 0,0, 12,1,0, 0,0, 0,0, C_ISSUE, 0);

    // JAL: issues and redirects; link register forwarded
    step("jal",      1, 0,0, 0,0,  1,1,0, 1,32'h40, 0,0, C_ISSUE | C_RDR | C_FL, 32'h40);
    step("jal_fl",   1, 0,0, 0,0,  2,1,0, 0,0, 0,0, C_FL | C_BUB, 0);
    step("rd_x1",    1, 1,1, 0,0, 13,1,0, 0,0, 0,0, C_ISSUE, 0);

    // JALR with busy rs1 stalls, then redirects once it issues
    step("ld_x9",    1, 0,0, 0,0,  9,1,1, 0,0, 0,0, C_ISSUE, 0);
    step("jalr_stl", 1, 9,1, 0,0,  1,1,0, 1,32'h80, 0,0, C_STALL | C_BUB, 0);
    step("jalr_iss", 1, 9,1, 0,0,  1,1,0, 1,32'h80, 0,0, C_ISSUE | C_RDR | C_FL, 32'h80);
    step("jalr_fl",  0, 0,0, 0,0,  0,0,0, 0,0, 0,0, C_FL | C_BUB, 0);

    // busy rd reloaded with the new (smaller) latency
    step("ld_x10",   1, 0,0, 0,0, 10,1,1, 0,0, 0,0, C_ISSUE, 0);
    step("alu_x10",  1, 0,0, 0,0, 10,1,0, 0,0, 0,0, C_ISSUE, 0);
    step("rd_x10",   1,10,1, 0,0, 14,1,0, 0,0, 0,0, C_ISSUE, 0);

    // async reset mid-stall
    step("ld_x5b",   1, 0,0, 0,0,  5,1,1, 0,0, 0,0, C_ISSUE, 0);
    drive(1, 5,1, 0,0, 15,1,0, 0,0, 0,0);
    #3;
    check_out("rst_pre", C_STALL | C_BUB, 0);
    reset = 1'b0;
    #1;
    check_out("rst_stl", C_NONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("rst_rd5",  1, 5,1, 0,0, 15,1,0, 0,0, 0,0, C_ISSUE, 0);

    // reset held across the edge of a load issue discards the write
    drive(1, 0,0, 0,0, 5,1,1, 0,0, 0,0);
    #3;
    reset = 1'b0;
    #1;
    check_out("rst_ld", C_NONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("rst_ld5",  1, 5,1, 0,0, 16,1,0, 0,0, 0,0, C_ISSUE, 0);

    // async reset mid-FLUSH
    step("br2",      0, 0,0, 0,0,  0,0,0, 0,0, 1,32'h300, C_RDR | C_FL | C_BUB, 32'h300);
    drive(1, 0,0, 0,0, 17,1,0, 0,0, 0,0);
    #3;
    check_out("fl_pre", C_FL | C_BUB, 0);
    reset = 1'b0;
    #1;
    check_out("rst_fl", C_NONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("fl_run",   1, 0,0, 0,0, 17,1,0, 0,0, 0,0, C_ISSUE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
